// File: rtl/read_buffer_pkg.sv
// Shared constants and types for the read_buffer block.
//   PIXELS_PER_BLOCK : words fetched per burst and depth of each ping-pong buffer
//   PIXEL_W / WORD_W : stored pixel width ({R,G,B}) and Avalon data width
//   CNT_W            : width of the per-block index counters
//   fetch_state_e    : fetch FSM state encoding (also exported for debug)
package read_buffer_pkg;
  localparam int PIXELS_PER_BLOCK = 6;
  localparam int PIXEL_W          = 24;
  localparam int WORD_W           = 32;
  localparam int CNT_W            = $clog2(PIXELS_PER_BLOCK);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    COLLECT = 2'd2,
    DONE    = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/flex_counter.sv
// Generic wrapping up-counter.
//   clear         : synchronous clear to 0 (wins over count_enable)
//   count_enable  : advance by one this cycle
//   rollover_val  : number of distinct counts; count_out runs 0..rollover_val-1
//   count_out     : current index
//   rollover_flag : high in the cycle whose enabled count wraps back to 0
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);
  logic [NUM_CNT_BITS-1:0] count_q, count_d;
  logic                    at_top;

  assign at_top        = (count_q == rollover_val - NUM_CNT_BITS'(1));
  assign rollover_flag = count_enable & at_top & ~clear;
  assign count_out     = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_enable) begin
      count_d = at_top ? '0 : count_q + NUM_CNT_BITS'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/read_buffer.sv
// Avalon-MM read master feeding a ping-pong pixel buffer.
// Fetches num_blocks bursts of PIXELS_PER_BLOCK words starting at
// start_address, keeps readdata[23:0] of each word, and streams the pixels
// out in address order.
//   clk, n_rst             : clock, asynchronous active-low reset
//   start/start_address/num_blocks : transfer request, sampled when idle
//   master_*               : Avalon-MM read master (pipelined reads)
//   pixel_data/valid/ready : pixel stream to the processing pipeline
//   busy, done_read        : transfer in progress / one-cycle completion pulse
//   fetch_state            : current fetch FSM state, for debug
//
// Handshakes: a read is accepted on a cycle where master_read=1 and
// master_waitrequest=0; until then address and read are held unchanged.
// A pixel moves on a cycle where pixel_valid=1 and pixel_ready=1;
// pixel_valid never drops and pixel_data never changes before that cycle.
module read_buffer
  import read_buffer_pkg::*;
#(
  parameter int ADDR_STRIDE = 4
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               start,
  input  logic [31:0]        start_address,
  input  logic [15:0]        num_blocks,
  output logic [31:0]        master_address,
  output logic               master_read,
  input  logic               master_waitrequest,
  input  logic [WORD_W-1:0]  master_readdata,
  input  logic               master_readdatavalid,
  output logic [PIXEL_W-1:0] pixel_data,
  output logic               pixel_valid,
  input  logic               pixel_ready,
  output logic               busy,
  output logic               done_read,
  output fetch_state_e       fetch_state
);
  localparam logic [CNT_W-1:0] BLOCK_LEN = CNT_W'(PIXELS_PER_BLOCK);

  fetch_state_e     state_q;
  logic [31:0]      addr_q;
  logic             mread_q;
  logic [15:0]      blocks_left_q;
  logic             busy_q;
  logic             done_q;
  logic [1:0]       full_q, full_d;
  logic             fill_sel_q;
  logic             drain_sel_q;
  logic [CNT_W-1:0] outstanding_q;

  logic [PIXEL_W-1:0] buf_q [2][PIXELS_PER_BLOCK];

  logic             start_go, accept, resp_ok, xfer;
  logic             issue_wrap, resp_wrap, drain_wrap;
  logic [CNT_W-1:0] resp_idx, drain_idx, unused_issue_cnt;
  logic             set_full, final_xfer;
  logic             unused_readdata_hi;

  assign unused_readdata_hi = ^master_readdata[WORD_W-1:PIXEL_W];

  assign start_go = (state_q == IDLE) & start;
  assign accept   = mread_q & ~master_waitrequest;
  // Only responses to reads this transfer actually issued are accepted;
  // stray or pre-reset responses find outstanding_q at 0 and are dropped.
  assign resp_ok  = master_readdatavalid & (outstanding_q != '0);
  assign xfer     = pixel_valid & pixel_ready;

  flex_counter #(.NUM_CNT_BITS(CNT_W)) u_issue_cnt (
    .clk(clk), .n_rst(n_rst), .clear(start_go), .count_enable(accept),
    .rollover_val(BLOCK_LEN), .count_out(unused_issue_cnt), .rollover_flag(issue_wrap)
  );

  flex_counter #(.NUM_CNT_BITS(CNT_W)) u_resp_cnt (
    .clk(clk), .n_rst(n_rst), .clear(start_go), .count_enable(resp_ok),
    .rollover_val(BLOCK_LEN), .count_out(resp_idx), .rollover_flag(resp_wrap)
  );

  flex_counter #(.NUM_CNT_BITS(CNT_W)) u_drain_cnt (
    .clk(clk), .n_rst(n_rst), .clear(start_go), .count_enable(xfer),
    .rollover_val(BLOCK_LEN), .count_out(drain_idx), .rollover_flag(drain_wrap)
  );

  // The last response of a block always lands in COLLECT: it trails the
  // last accept, which is what moves the FSM out of ISSUE.
  assign set_full = (state_q == COLLECT) & resp_wrap;

  // Last pixel of the whole transfer: everything fetched, this buffer
  // empties now and the other one holds nothing.
  assign final_xfer = (state_q == COLLECT) & (blocks_left_q == '0) &
                      drain_wrap & ~full_q[~drain_sel_q];

  // Fill and drain always target different buffers when both events
  // coincide, so both updates apply.
  always_comb begin
    full_d = full_q;
    if (set_full)   full_d[fill_sel_q]  = 1'b1;
    if (drain_wrap) full_d[drain_sel_q] = 1'b0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      mread_q       <= 1'b0;
      blocks_left_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      full_q        <= '0;
      fill_sel_q    <= 1'b0;
      drain_sel_q   <= 1'b0;
      outstanding_q <= '0;
    end else begin
      done_q <= 1'b0;
      full_q <= full_d;
      if (drain_wrap) drain_sel_q <= ~drain_sel_q;

      case ({accept, resp_ok})
        2'b10:   outstanding_q <= outstanding_q + CNT_W'(1);
        2'b01:   outstanding_q <= outstanding_q - CNT_W'(1);
        default: ;
      endcase

      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (num_blocks != '0) begin
              state_q       <= ISSUE;
              addr_q        <= start_address;
              blocks_left_q <= num_blocks;
              busy_q        <= 1'b1;
              mread_q       <= 1'b1;  // both buffers are empty when idle
              fill_sel_q    <= 1'b0;
              drain_sel_q   <= 1'b0;
            end else begin
              state_q <= DONE;
            end
          end
        end
        ISSUE: begin
          if (accept) begin
            addr_q <= addr_q + 32'(ADDR_STRIDE);
            if (issue_wrap) begin
              state_q <= COLLECT;
              mread_q <= 1'b0;
            end
          end else if (!mread_q) begin
            // Stalled on a full target buffer; resume once it drains.
            mread_q <= ~full_d[fill_sel_q];
          end
        end
        COLLECT: begin
          if (set_full) begin
            fill_sel_q    <= ~fill_sel_q;
            blocks_left_q <= blocks_left_q - 16'd1;
            if (blocks_left_q != 16'd1) begin
              state_q <= ISSUE;
              mread_q <= ~full_d[~fill_sel_q];
            end
          end else if (final_xfer) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        DONE: begin
          // Arriving with done_q already set means the pulse is in flight;
          // the empty-transfer path arrives with it clear and raises it here.
          state_q <= IDLE;
          done_q  <= ~done_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < PIXELS_PER_BLOCK; i++) begin
          buf_q[b][i] <= '0;
        end
      end
    end else if (resp_ok) begin
      buf_q[fill_sel_q][resp_idx] <= master_readdata[PIXEL_W-1:0];
    end
  end

  assign master_address = addr_q;
  assign master_read    = mread_q;
  assign pixel_valid    = full_q[drain_sel_q];
  assign pixel_data     = buf_q[drain_sel_q][drain_idx];
  assign busy           = busy_q;
  assign done_read      = done_q;
  assign fetch_state    = state_q;
endmodule

// File: tb/tb_read_buffer.sv
module tb_read_buffer;
  import read_buffer_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         n_rst;
  logic         start;
  logic [31:0]  start_address;
  logic [15:0]  num_blocks;
  logic [31:0]  master_address;
  logic         master_read;
  logic         master_waitrequest;
  logic [31:0]  master_readdata;
  logic         master_readdatavalid;
  logic [23:0]  pixel_data;
  logic         pixel_valid;
  logic         pixel_ready;
  logic         busy;
  logic         done_read;
  fetch_state_e fetch_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  read_buffer dut (
    .clk(clk), .n_rst(n_rst), .start(start), .start_address(start_address),
    .num_blocks(num_blocks), .master_address(master_address),
    .master_read(master_read), .master_waitrequest(master_waitrequest),
    .master_readdata(master_readdata), .master_readdatavalid(master_readdatavalid),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .busy(busy), .done_read(done_read), .fetch_state(fetch_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [23:0] exp_q[$];
  logic [23:0] mon_e;
  logic [31:0] mem_base, exp_addr;
  int          read_cnt, pix_cnt, rdv_cnt;
  int          stall_at = -1, stall_left = 0, stall_hits = 0;
  int          rdv6_cyc, first_valid_cyc, last_xfer_cyc, done_cyc;
  bit          valid_seen, done_seen, spur;
  bit          s0_v = 0, s1_v = 0;
  logic [31:0] s0_d = '0, s1_d = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- Avalon slave model + pixel monitor ----------------
  // Evaluated mid-low-phase: decisions here take effect at the next posedge.
  always begin
    @(negedge clk);
    #1;
    // response pipeline: data returns 2 cycles after its accept
    master_readdatavalid = s1_v;
    master_readdata      = s1_v ? s1_d : 32'hDEAD_BEEF;
    if (s1_v) begin
      rdv_cnt++;
      if (rdv_cnt == 6) rdv6_cyc = cyc;
    end else if (spur) begin
      master_readdatavalid = 1'b1;
      master_readdata      = 32'hFFAB_CDEF;
      spur = 0;
    end
    s1_v = s0_v;
    s1_d = s0_d;
    s0_v = 0;
    // request side
    master_waitrequest = 1'b0;
    if (master_read) begin
      if (read_cnt == stall_at && stall_left > 0) begin
        master_waitrequest = 1'b1;
        stall_left--;
        stall_hits++;
        check("stall_addr", master_address, exp_addr);
      end else begin
        check("rd_addr", master_address, exp_addr);
        s0_v = 1;
        s0_d = 32'hFF00_0000 + ((master_address - mem_base) >> 2);
        exp_addr = exp_addr + 32'd4;
        read_cnt++;
      end
    end
    // pixel stream
    if (pixel_valid && !valid_seen) begin
      valid_seen = 1;
      first_valid_cyc = cyc;
    end
    if (pixel_valid && pixel_ready) begin
      if (exp_q.size() == 0) begin
        check("pix_extra", 32'(exp_q.size()), 32'd1);
      end else begin
        mon_e = exp_q.pop_front();
        check("pix", {8'h00, pixel_data}, {8'h00, mon_e});
      end
      pix_cnt++;
      last_xfer_cyc = cyc + 1;
    end
    if (done_read) begin
      done_seen = 1;
      done_cyc  = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic arm(input logic [31:0] base, input int npix);
    exp_q.delete();
    for (int i = 0; i < npix; i++) exp_q.push_back(24'(i));
    mem_base   = base;
    exp_addr   = base;
    read_cnt   = 0;
    pix_cnt    = 0;
    rdv_cnt    = 0;
    valid_seen = 0;
    done_seen  = 0;
    stall_at   = -1;
    stall_left = 0;
    stall_hits = 0;
  endtask

  task automatic pulse_start(input logic [31:0] a, input logic [15:0] n);
    start = 1'b1;
    start_address = a;
    num_blocks = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done_seen; i++) @(negedge clk);
    check("done_seen", 32'(done_seen), 32'd1);
  endtask

  task automatic post_checks(input int n);
    check("reads", 32'(read_cnt), 32'(n));
    check("pixels", 32'(pix_cnt), 32'(n));
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("busy_off", 32'(busy), 32'd0);
    check("done_lat", 32'(done_cyc), 32'(last_xfer_cyc));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed tests ----------------
  initial begin
    n_rst = 1'b0; start = 1'b0; start_address = '0; num_blocks = '0;
    pixel_ready = 1'b0; master_waitrequest = 1'b0;
    master_readdata = '0; master_readdatavalid = 1'b0;
    spur = 0;
    arm(32'h0, 0);

    // reset
    repeat (3) @(negedge clk);
    check("rst_read", 32'(master_read), 32'd0);
    check("rst_addr", master_address, 32'd0);
    check("rst_valid", 32'(pixel_valid), 32'd0);
    check("rst_data", {8'h00, pixel_data}, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done_read), 32'd0);
    check("rst_state", 32'(fetch_state), 32'(IDLE));
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_read", 32'(master_read), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);

    // single block, with a stray readdatavalid beforehand
    arm(32'h1000, 6);
    spur = 1;
    repeat (3) @(negedge clk);
    pixel_ready = 1'b1;
    pulse_start(32'h1000, 16'd1);
    check("first_read", 32'(master_read), 32'd1);
    check("first_addr", master_address, 32'h1000);
    check("busy_on", 32'(busy), 32'd1);
    wait_done(100);
    check("valid_rise", 32'(first_valid_cyc), 32'(rdv6_cyc + 1));
    post_checks(6);

    // waitrequest stall on the 3rd read
    arm(32'h1000, 6);
    stall_at = 2;
    stall_left = 4;
    pulse_start(32'h1000, 16'd1);
    wait_done(100);
    check("stall_cycles", 32'(stall_hits), 32'd4);
    post_checks(6);

    // backpressure: three blocks, consumer stalled
    arm(32'h2000, 18);
    pixel_ready = 1'b0;
    pulse_start(32'h2000, 16'd3);
    repeat (40) @(negedge clk);
    check("bp_reads", 32'(read_cnt), 32'd12);
    check("bp_read_low", 32'(master_read), 32'd0);
    check("bp_valid", 32'(pixel_valid), 32'd1);
    check("bp_data", {8'h00, pixel_data}, 32'd0);
    check("bp_busy", 32'(busy), 32'd1);
    pixel_ready = 1'b1;
    wait_done(200);
    post_checks(18);

    // zero-length transfer
    arm(32'h3000, 0);
    pulse_start(32'h3000, 16'd0);
    check("z_read", 32'(master_read), 32'd0);
    check("z_done_early", 32'(done_read), 32'd0);
    @(negedge clk);
    check("z_done", 32'(done_read), 32'd1);
    check("z_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("z_done_pulse", 32'(done_read), 32'd0);
    check("z_reads", 32'(read_cnt), 32'd0);

    // second start while busy is ignored
    arm(32'h1000, 6);
    pulse_start(32'h1000, 16'd1);
    repeat (2) @(negedge clk);
    pulse_start(32'h5000, 16'd2);
    wait_done(100);
    post_checks(6);
    repeat (5) @(negedge clk);
    check("ign_read", 32'(master_read), 32'd0);
    check("ign_reads", 32'(read_cnt), 32'd6);

    // reset in the middle of a transfer, then a fresh start
    arm(32'h1000, 12);
    pulse_start(32'h1000, 16'd2);
    for (int i = 0; i < 50 && read_cnt < 4; i++) @(negedge clk);
    check("mr_reach4", 32'(read_cnt >= 4), 32'd1);
    n_rst = 1'b0;
    #1;
    check("mr_read", 32'(master_read), 32'd0);
    check("mr_valid", 32'(pixel_valid), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_addr", master_address, 32'd0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    arm(32'h4000, 6);
    @(negedge clk);
    pulse_start(32'h4000, 16'd1);
    check("mr_first_addr", master_address, 32'h4000);
    wait_done(100);
    post_checks(6);

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/read_buffer.md
# read_buffer

Avalon-MM read master and ping-pong pixel buffer that streams stored image pixels out of SDRAM into the cartoonifier processing pipeline. It is the read-side counterpart of the write buffer. It fetches fixed blocks of 32-bit words, keeps the low 24 bits of each as an RGB pixel, and hands pixels downstream one at a time under a valid/ready handshake. Two 6-pixel buffers let the next block be fetched while the current one drains.

## Interface
- PIXELS_PER_BLOCK, 6, pixels fetched per block and buffer depth
- ADDR_STRIDE, 4, byte increment between consecutive word addresses
- clk  in  1  clock
- n_rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a transfer; ignored while busy
- start_address  in  32  byte address of first pixel word; sampled on start
- num_blocks  in  16  number of blocks to transfer; sampled on start
- master_address  out  32  Avalon read address
- master_read  out  1  Avalon read request
- master_waitrequest  in  1  slave stall; read is accepted when master_read=1 and waitrequest=0
- master_readdata  in  32  returned word; bits [31:24] ignored
- master_readdatavalid  in  1  readdata valid this cycle
- pixel_data  out  24  current pixel, {R,G,B}
- pixel_valid  out  1  pixel_data valid
- pixel_ready  in  1  consumer accepts pixel; transfer = valid & ready
- busy  out  1  transfer in progress
- done_read  out  1  one-cycle pulse when the last pixel of the last block is consumed

## Operation
- Two buffers, buf0 and buf1, each PIXELS_PER_BLOCK x 24. Each has a registered full flag. fill_sel selects the buffer being fetched; drain_sel selects the buffer being consumed. Both are 0 after start.
- Fetch FSM states: IDLE, ISSUE, COLLECT, DONE.
  - IDLE: on start with num_blocks≠0, latch the address and block count, set busy, go to ISSUE. With num_blocks=0, go to DONE.
  - ISSUE: requires full[fill_sel]=0; otherwise hold master_read=0. Assert master_read at the current address. On acceptance, increment the address by ADDR_STRIDE and the issue count. After the 6th acceptance, go to COLLECT.
  - Reads are pipelined, so readdatavalid may arrive while still in ISSUE. Each readdatavalid writes readdata[23:0] into the fill buffer at index resp_cnt, then resp_cnt++.
  - COLLECT: when resp_cnt reaches 6, set full[fill_sel], toggle fill_sel, and decrement blocks_left. If blocks_left≠0, go to ISSUE; otherwise stay until draining completes.
  - DONE: when the final block has drained (or immediately for num_blocks=0), pulse done_read, clear busy, return to IDLE.
- Drain side:
  - pixel_valid = full[drain_sel].
  - pixel_data = buffer[drain_sel][drain_idx].
  - On each transfer, drain_idx++. When the 6th pixel transfers, clear full[drain_sel], toggle drain_sel, and reset drain_idx to 0.
- Pixel order out equals address order in; the lowest address comes out first.
- Simultaneous set of one buffer's full flag and clear of the other's in the same cycle: both take effect.
- readdatavalid with no outstanding read is ignored.
- start while busy is ignored.

## Timing
- Reset values:
  - master_read=0, master_address=0, pixel_valid=0, pixel_data=0, busy=0, done_read=0.
  - Buffers and all counters are 0; FSM is in IDLE.
- Reset asserted mid-transfer clears everything asynchronously. master_read drops immediately, and outstanding responses after reset are ignored.
- master_address and master_read are registered and held stable while waitrequest=1.
- First read is issued the cycle after start.
- pixel_valid rises one cycle after the 6th readdatavalid of a block (registered full flag).
- Zero-wait drain: one pixel per cycle while pixel_ready=1.
- Maximum outstanding data: 12 pixels (both buffers full). The fetcher stalls with master_read=0 until a buffer frees.
- done_read fires the cycle after the final transfer, or 2 cycles after start when num_blocks=0.

## Structure
- Shared package read_buffer_pkg: PIXELS_PER_BLOCK, PIXEL_W=24, WORD_W=32, and the fetch state enum (IDLE, ISSUE, COLLECT, DONE).
- Reuse the existing flex_counter sub-module (rollover at 6) for the issue, response and drain counters.
- Buffers, flags and FSM live in read_buffer.

## Test plan
- Reset: hold n_rst=0 for 3 cycles -> all outputs 0; master_read stays 0 after release with no start.
- Single block: start_address=0x1000, num_blocks=1, no waitrequest, readdatavalid 2 cycles after each accept, readdata=0xFF000000+i -> reads at 0x1000..0x1014; pixels 0x000000..0x000005 out in order; then done_read pulse and busy=0.
- Waitrequest stall: waitrequest=1 for 4 cycles on the 3rd read -> master_address=0x1008 and master_read=1 held stable throughout; no address skipped.
- Backpressure: num_blocks=3, pixel_ready=0 -> exactly 12 reads issued, then master_read=0. Raising pixel_ready drains 6 pixels, the 3rd block is fetched, and 18 pixels emerge in address order.
- Edge starts: num_blocks=0 -> no master_read, done_read 2 cycles after start. A second start pulse during a transfer -> ignored; address sequence unchanged.
- Mid-transfer reset: assert n_rst after the 4th accept -> master_read=0 at once, pixel_valid=0. A new start then replays from the new start_address.
